// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_ctrl
// Purpose  : Sequential radix-4 Booth controller for an 11x11 unsigned
//            multiply. It reuses one external partial-product selector
//            across the six Booth digits. One digit is selected and
//            accumulated per cycle. A 22-bit product is returned with a
//            one-cycle done pulse.
// Ports    : clk      - rising-edge clock
//            rst      - synchronous active-low reset
//            start    - multiply request, accepted only when idle
//            mcand    - multiplicand, sampled on an accepted start
//            mplier   - multiplier, sampled on an accepted start
//            mux_op   - selector operand {1'b0, mcand}
//            mux_sel  - Booth triplet of the current digit (0 when not running)
//            mux_pp   - selector result, combinational return, same cycle
//            busy     - high while running and in the done cycle
//            done     - one-cycle pulse, product valid
//            product  - result, held until the next accepted start
// Options  : BOOTH_CTRL_EARLY_EXIT_EN - when defined, the block finishes as
//            soon as every remaining multiplier digit is zero.
// Revision : 1.0 - initial release
// ============================================================================
module booth_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] mcand,
    input  logic [10:0] mplier,
    output logic [11:0] mux_op,
    output logic [2:0]  mux_sel,
    input  logic [11:0] mux_pp,
    output logic        busy,
    output logic        done,
    output logic [21:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_DIGIT = 3'd5;

    state_t      state_q;
    logic [10:0] mcand_q;
    logic [11:0] y_q;
    logic [23:0] acc_q;
    logic [2:0]  idx_q;
    logic        busy_q;
    logic        done_q;
    logic [21:0] product_q;

    logic [2:0]  trip_w;
    logic [3:0]  shamt_w;
    logic [23:0] pp_ext_w;
    logic [23:0] corr_w;
    logic [23:0] acc_d;
    logic        last_w;

    // Booth triplet {y[2i+1], y[2i], y[2i-1]} with y[-1] = 0.
    always_comb begin
        trip_w = 3'b000;
        case (idx_q)
            3'd0:    trip_w = {y_q[1], y_q[0], 1'b0};
            3'd1:    trip_w = y_q[3:1];
            3'd2:    trip_w = y_q[5:3];
            3'd3:    trip_w = y_q[7:5];
            3'd4:    trip_w = y_q[9:7];
            3'd5:    trip_w = y_q[11:9];
            default: trip_w = 3'b000;
        endcase
    end

    // Last digit to process. With early exit, stop once the multiplier bits
    // feeding all later triplets are zero (those digits would all select 0).
    always_comb begin
        last_w = (idx_q == LAST_DIGIT);
`ifdef BOOTH_CTRL_EARLY_EXIT_EN
        case (idx_q)
            3'd0:    last_w = (y_q[11:1] == 11'd0);
            3'd1:    last_w = (y_q[11:3] == 9'd0);
            3'd2:    last_w = (y_q[11:5] == 7'd0);
            3'd3:    last_w = (y_q[11:7] == 5'd0);
            3'd4:    last_w = (y_q[11:9] == 3'd0);
            default: last_w = (idx_q == LAST_DIGIT);
        endcase
`endif
    end

    always_comb begin
        mux_sel  = (state_q == ST_RUN) ? trip_w : 3'b000;
        shamt_w  = {idx_q, 1'b0};
        // +-2A of an 11-bit operand needs 13 bits, so mux_pp[11] is not a
        // reliable sign. The true sign is the triplet MSB: negative cases set
        // it, and 000 (zero) and 111 (all ones plus the +1) sign-extend
        // correctly with it as well.
        pp_ext_w = {{12{mux_sel[2]}}, mux_pp} << shamt_w;
        // +1 completing the two's complement of inverted (negative) cases.
        corr_w   = {23'd0, mux_sel[2]} << shamt_w;
        acc_d    = acc_q + pp_ext_w + corr_w;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= 11'd0;
            y_q       <= 12'd0;
            acc_q     <= 24'd0;
            idx_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 22'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q <= mcand;
                        y_q     <= {1'b0, mplier};
                        acc_q   <= 24'd0;
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    if (last_w) begin
                        // Bits above 21 are discarded; the true product fits.
                        product_q <= acc_d[21:0];
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mux_op  = {1'b0, mcand_q};
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_seq_ctrl
// Purpose  : Self-checking bench for booth_seq_ctrl. It models the Booth
//            selector combinationally and checks the following:
//            - reset state and cycle timing
//            - the Booth triplet sequence
//            - products of directed and random operands
//            - back-to-back starts and mid-multiply reset
//            It honours BOOTH_CTRL_EARLY_EXIT_EN for the expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] mcand;
    logic [10:0] mplier;
    logic [11:0] mux_op;
    logic [2:0]  mux_sel;
    logic [11:0] mux_pp;
    logic        busy;
    logic        done;
    logic [21:0] product;

    int n_checks;
    int n_fail;

    booth_seq_ctrl u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .mux_op  (mux_op),
        .mux_sel (mux_sel),
        .mux_pp  (mux_pp),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Radix-4 Booth selector (negative cases in one's complement).
    function automatic logic [11:0] sel_model(input logic [11:0] op, input logic [2:0] s);
        logic [11:0] two_a;
        two_a = op << 1;
        case (s)
            3'b000:          return 12'h000;
            3'b001, 3'b010:  return op;
            3'b011:          return two_a;
            3'b100:          return ~two_a;
            3'b101, 3'b110:  return ~op;
            default:         return 12'hFFF;
        endcase
    endfunction

    assign mux_pp = sel_model(mux_op, mux_sel);

    // Expected triplet for digit i of multiplier b.
    function automatic logic [2:0] trip_model(input logic [10:0] b, input int i);
        logic [12:0] ye;
        ye = {1'b0, b, 1'b0};
        return ye[2*i +: 3];
    endfunction

    // Expected cycles from the start edge to the done cycle.
    function automatic int lat_model(input logic [10:0] b);
        logic [11:0] y;
        y = {1'b0, b};
`ifdef BOOTH_CTRL_EARLY_EXIT_EN
        for (int i = 0; i < 5; i++) begin
            if ((y >> (2*i + 1)) == 12'd0) return i + 2;
        end
`else
        if (y == 12'hFFF) return 0;
`endif
        return 7;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One multiply: start for a single cycle, then check every cycle up to
    // and including the return to idle. Operand inputs are scrambled while
    // busy to show they are not resampled.
    task automatic run_mul(input logic [10:0] a, input logic [10:0] b, input bit chk_sel);
        int          lat;
        logic [31:0] exp_p;
        lat   = lat_model(b);
        exp_p = 32'(a) * 32'(b);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start  = 1'b0;
                mcand  = 11'($urandom);
                mplier = 11'($urandom);
                check_eq("mux_op", 32'(mux_op), {21'd0, a});
            end
            if (chk_sel) begin
                check_eq("busy", 32'(busy), 32'(n <= lat));
                if (n < lat) check_eq("mux_sel", 32'(mux_sel), 32'(trip_model(b, n - 1)));
                else         check_eq("mux_sel_idle", 32'(mux_sel), 32'd0);
            end
            check_eq("done", 32'(done), 32'(n == lat));
            if (n >= lat) check_eq("product", 32'(product), exp_p);
        end
    endtask

    initial begin
        int lat;
        int n_done;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        mcand    = 11'd0;
        mplier   = 11'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy",    32'(busy),    32'd0);
        check_eq("rst_done",    32'(done),    32'd0);
        check_eq("rst_product", 32'(product), 32'd0);
        check_eq("rst_mux_op",  32'(mux_op),  32'd0);
        check_eq("rst_mux_sel", 32'(mux_sel), 32'd0);
        rst = 1'b1;

        // Directed vectors
        run_mul(11'h7FF, 11'h7FF, 1'b1);   // 0x3FF001
        run_mul(11'd3,   11'd5,   1'b1);   // 15
        run_mul(11'h123, 11'd1,   1'b1);   // 0x123
        run_mul(11'h123, 11'd0,   1'b1);   // 0
        run_mul(11'h7FF, 11'h555, 1'b1);
        run_mul(11'h7FF, 11'h2AA, 1'b1);
        run_mul(11'h7FF, 11'h7FE, 1'b1);
        run_mul(11'h400, 11'h006, 1'b1);   // +-2A with a large multiplicand
        run_mul(11'd0,   11'h7FF, 1'b1);

        // start held high: a new multiply every lat+1 cycles
        lat    = lat_model(11'd3);
        n_done = 0;
        @(negedge clk);
        start  = 1'b1;
        mcand  = 11'd2;
        mplier = 11'd3;
        @(posedge clk);
        for (int n = 1; n <= 2*lat + 1; n++) begin
            @(negedge clk);
            if (done) n_done++;
            check_eq("b2b_done", 32'(done), 32'((n == lat) || (n == 2*lat + 1)));
            if (n == lat || n == 2*lat + 1) check_eq("b2b_product", 32'(product), 32'd6);
            if (n == 2) begin
                mcand  = 11'd5;
                mplier = 11'd7;
            end
            if (n == lat) begin
                mcand  = 11'd2;
                mplier = 11'd3;
            end
        end
        start = 1'b0;
        check_eq("b2b_count", 32'(n_done), 32'd2);

        // Reset in the middle of a multiply
        @(negedge clk);
        start  = 1'b1;
        mcand  = 11'h7FF;
        mplier = 11'h7FF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy",    32'(busy),    32'd0);
        check_eq("abort_done",    32'(done),    32'd0);
        check_eq("abort_product", 32'(product), 32'd0);
        check_eq("abort_mux_sel", 32'(mux_sel), 32'd0);
        rst = 1'b1;
        run_mul(11'd10, 11'd10, 1'b1);     // 100

        // Random sweep
        for (int k = 0; k < 3000; k++) begin
            run_mul(11'($urandom), 11'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
